// File: rtl/fifo_rd_packer.sv
// Purpose: pops narrow words from a first-word-fall-through FIFO and packs PACK of them into one keep-masked beat.
// Latency: the beat appears one cycle after the pop that completes it, or after the pop that serves a flush.
// Backpressure: popping pauses only when the last lane is reached and the output slot is still held; build with RD_PACKER_TIMEOUT_EN for idle auto-flush.
module fifo_rd_packer #(
  parameter int DATA_SIZE = 8,
  parameter int PACK      = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic                      rd_empty,
  input  logic [DATA_SIZE-1:0]      rd_data,
  output logic                      rd_inc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_SIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]           out_keep
);

  localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CW = $clog2(PACK + 1);
  localparam int KW = PACK + 1;
  localparam logic [IW-1:0] LAST = IW'(PACK - 1);

  // Catch out-of-range parameters at elaboration time.
  if (PACK < 2 || PACK > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("fifo_rd_packer: PACK or TIMEOUT out of range");
  end

  logic [PACK-1:0][DATA_SIZE-1:0] acc_q, acc_d;
  logic [PACK-1:0][DATA_SIZE-1:0] data_q, data_d;
  logic [PACK-1:0][DATA_SIZE-1:0] beat;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [PACK-1:0]                keep_q, keep_d, keep_part;
  logic                           valid_q, valid_d;
  logic                           pend_q, pend_d;
  logic                           slot_free, pop, full_beat, serve, tmo_hit;
  logic [CW-1:0]                  count;
  logic [KW-1:0]                  keep_wide;

  // The last lane may only be filled when the slot can take the completed beat.
  assign slot_free = !valid_q || out_ready;
  assign rd_inc    = !rd_rst && !rd_empty && ((idx_q < LAST) || slot_free);
  assign pop       = rd_inc;
  assign full_beat = pop && (idx_q == LAST);
  // A full beat has priority; the pending flush then sees an empty accumulator.
  assign serve     = pend_q && slot_free && !full_beat;
  assign count     = CW'(idx_q) + CW'(pop);
  assign keep_wide = (KW'(1) << count) - KW'(1);
  assign keep_part = keep_wide[PACK-1:0];

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;

`ifdef RD_PACKER_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;

  // Count idle cycles with a partial beat held; reaching TIMEOUT raises a flush.
  always_comb begin
    idle_d  = idle_q;
    tmo_hit = 1'b0;
    if (pop || flush || idx_q == '0) begin
      idle_d = '0;
    end else if (!pend_q) begin
      idle_d  = idle_q + 8'd1;
      tmo_hit = (idle_d == 8'(TIMEOUT));
    end
  end

  // Idle counter register.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Accumulate popped words and move full or flushed beats into the output slot.
  always_comb begin
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    beat    = '0;
    // Lanes below idx come from the accumulator, the lane at idx from the word popping now.
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(idx_q))                beat[i] = acc_q[i];
      else if (i == int'(idx_q) && pop)   beat[i] = rd_data;
    end
    if (valid_q && out_ready) valid_d = 1'b0;
    if (pop) begin
      acc_d[idx_q] = rd_data;
      idx_d        = idx_q + IW'(1);
    end
    if (full_beat) begin
      idx_d   = '0;
      data_d  = beat;
      keep_d  = '1;
      valid_d = 1'b1;
    end else if (serve && count != '0) begin
      idx_d   = '0;
      data_d  = beat;
      keep_d  = keep_part;
      valid_d = 1'b1;
    end
    pend_d = serve ? 1'b0 : (pend_q || flush || tmo_hit);
  end

  // State registers; reset drops any partial words and the held beat.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Purpose: drives fifo_rd_packer from a queue-backed FIFO and checks it against a word-list model.
// Latency: one model step per clock; outputs sampled 1 time unit after the falling edge.
// Backpressure: out_ready is driven directly by the bench, both directed and random.
module tb_fifo_rd_packer;
  localparam int DS      = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic              rd_clk = 1'b0;
  logic              rd_rst, rd_empty, rd_inc, flush, out_valid, out_ready;
  logic [DS-1:0]     rd_data;
  logic [DS*PACK-1:0] out_data;
  logic [PACK-1:0]   out_keep;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(.DATA_SIZE(DS), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .rd_data(rd_data),
    .rd_inc(rd_inc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep)
  );

  int checks = 0;
  int errors = 0;

  // FIFO contents and the words the model has popped but not yet emitted.
  logic [7:0]  fifo_q[$];
  logic [7:0]  held[$];
  logic        m_known = 1'b0;
  logic        m_valid = 1'b0, m_clean = 1'b1, m_pend = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_keep = '0;
  int          m_cnt = 0;
  int          beats = 0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_keep = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_beat();
    m_data = '0;
    foreach (held[i]) m_data[i*8 +: 8] = held[i];
    m_keep  = 4'((1 << held.size()) - 1);
    m_valid = 1'b1;
    m_clean = 1'b0;
    held.delete();
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst, input logic stall, input logic fl, input logic rdy);
    logic sf, exp_inc, hit, served;
    rd_rst    = rst;
    flush     = fl;
    out_ready = rdy;
    rd_empty  = stall || (fifo_q.size() == 0);
    rd_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    #1;
    sf      = !m_valid || rdy;
    exp_inc = !rst && !rd_empty && ((held.size() < PACK - 1) || sf);
    if (m_known) begin
      chk("rd_inc", rd_inc, exp_inc);
      chk("out_valid", out_valid, m_valid);
      if (m_valid || m_clean) begin
        chk("out_data", out_data, m_data);
        chk("out_keep", out_keep, m_keep);
      end
    end
    if (out_valid === 1'b1 && rdy) begin
      beats++;
      last_data = out_data;
      last_keep = out_keep;
    end
    if (rst) begin
      held.delete();
      m_known = 1'b1; m_valid = 1'b0; m_clean = 1'b1;
      m_data = '0; m_keep = '0; m_pend = 1'b0; m_cnt = 0;
    end else begin
      hit    = 1'b0;
      served = 1'b0;
      if (exp_inc || fl || held.size() == 0) m_cnt = 0;
      else if (!m_pend) begin
        m_cnt++;
`ifdef RD_PACKER_TIMEOUT_EN
        if (m_cnt == TIMEOUT) hit = 1'b1;
`endif
      end
      if (m_valid && rdy) m_valid = 1'b0;
      if (exp_inc) held.push_back(fifo_q.pop_front());
      if (exp_inc && held.size() == PACK) load_beat();
      else if (m_pend && sf) begin
        served = 1'b1;
        if (held.size() != 0) load_beat();
      end
      m_pend = served ? 1'b0 : (m_pend || fl || hit);
    end
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  initial begin
    int b0;
    rd_rst = 1'b1; rd_empty = 1'b1; rd_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(negedge rd_clk);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Full beat with ready held high.
    b0 = beats;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (6) step(0, 0, 0, 1);
    chk("full_beats", beats - b0, 1);
    chk("full_data", last_data, 32'h44332211);
    chk("full_keep", last_keep, 4'hF);

    // Backpressure: first beat held, popping stops at the last lane.
    b0 = beats;
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (10) step(0, 0, 0, 0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_data", out_data, 32'h04030201);
    chk("bp_fifo_left", fifo_q.size(), 1);
    repeat (2) step(0, 0, 0, 1);
    chk("bp_beats", beats - b0, 2);
    chk("bp_data2", last_data, 32'h08070605);

    // Flush of a two-word partial beat, then flush with nothing held.
    b0 = beats;
    push(8'hAA); push(8'hBB);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("flush_beats", beats - b0, 1);
    chk("flush_data", last_data, 32'h0000BBAA);
    chk("flush_keep", last_keep, 4'b0011);
    b0 = beats;
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("idle_flush_beats", beats - b0, 0);

    // Flush arriving with the fourth pop: one full beat, no empty beat after it.
    b0 = beats;
    push(8'h21); push(8'h43); push(8'h65); push(8'h87);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    repeat (4) step(0, 0, 0, 1);
    chk("sim_beats", beats - b0, 1);
    chk("sim_keep", last_keep, 4'hF);
    chk("sim_data", last_data, 32'h87654321);

    // Reset after two pops drops them; the next four words form a clean beat.
    b0 = beats;
    push(8'hA1); push(8'hA2);
    repeat (2) step(0, 0, 0, 1);
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    step(1, 0, 0, 1);
    chk("rst_keep", out_keep, 4'h0);
    repeat (6) step(0, 0, 0, 1);
    chk("rst_beats", beats - b0, 1);
    chk("rst_data", last_data, 32'hC4C3C2C1);

    // Single word left idle: timeout flush only when the feature is built in.
    b0 = beats;
    push(8'h5A);
    repeat (25) step(0, 0, 0, 1);
`ifdef RD_PACKER_TIMEOUT_EN
    chk("tmo_beats", beats - b0, 1);
    chk("tmo_data", last_data, 32'h0000005A);
    chk("tmo_keep", last_keep, 4'b0001);
`else
    chk("tmo_beats", beats - b0, 0);
`endif
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);

    // Random traffic, stalls, flushes, backpressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if ((c % 400) < 300 && fifo_q.size() < 6 && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 6)) push(8'($urandom));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
